regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- 32-entry general-purpose register file with two combinational read ports, one write-back port, and a per-register busy scoreboard.
- Sits directly upstream of the pipeline operand registers: it feeds their inputs and enables.
- Decode issues an instruction with rs1/rs2/rd. The block returns operands and a ready flag.
- Write-back retires results into storage and clears busy bits.

Parameters:
- WIDTH, default `WIDTH (32, from common.h): data word width.
- NREG, default 32: number of architectural registers.
- ADDR_W, default 5: register index width, equal to clog2(NREG).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_rs1  in  ADDR_W  source 1 index.
- issue_rs2  in  ADDR_W  source 2 index.
- issue_rd  in  ADDR_W  destination index; 0 means no destination.
- issue_ready  out  1  instruction accepted this cycle; operands on rdata1/rdata2 are valid.
- rdata1  out  WIDTH  operand for issue_rs1.
- rdata2  out  WIDTH  operand for issue_rs2.
- wb_valid  in  1  write-back strobe.
- wb_rd  in  ADDR_W  write-back destination.
- wb_data  in  WIDTH  write-back value.
- busy_cnt  out  ADDR_W+1  number of registers currently marked busy.

Behaviour:
- Reset (rstn low, asynchronous): all storage entries cleared to 0, all busy bits cleared, busy_cnt = 0.
- Release of reset is synchronised externally. Reset asserted mid-operation discards pending busy state, and any write-back in that cycle is lost.
- Register 0: always reads 0, is never written, and is never busy. wb_rd = 0 and issue_rd = 0 are no-ops for storage and scoreboard.
- Reads are combinational, with zero latency from issue_rs1/issue_rs2 to rdata1/rdata2.
- hazard = busy_eff[rs1] | busy_eff[rs2] | busy_eff[rd], where busy_eff is defined under Optional Feature.
- issue_ready = issue_valid & ~hazard.
  - The WAW check on rd forbids two in-flight writers to one register.
- Issue accept (issue_ready = 1): busy[issue_rd] is set at the next edge when issue_rd != 0.
- issue_valid with hazard: nothing changes; decode holds its inputs and retries.
- Write-back (wb_valid = 1, wb_rd != 0): storage[wb_rd] takes wb_data at the edge and busy[wb_rd] clears.
- Write-back to a non-busy register is still written. This is legal, e.g. the initial loader.
- Same-cycle write-back and issue setting the same register: the set wins, so busy stays 1 and the data is written.
- busy_cnt is registered and always equals popcount(busy). It is updated by +1, -1, or 0 per cycle according to the simultaneous set/clear events.
- Counter never wraps, because at most NREG-1 entries can be busy.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined:
  - When wb_valid & wb_rd == rsX & rsX != 0, rdataX = wb_data (write-through, same cycle).
  - busy_eff[r] = busy[r] & ~(wb_valid & wb_rd == r), so the retiring register does not stall.
  - Issue latency after the producer's write-back: 0 cycles.
- Undefined:
  - rdataX = storage[rsX] only, and busy_eff = busy.
  - A consumer of a register retiring this cycle stalls exactly one cycle and issues on the next.

Decomposition:
- Additions to common.h (shared include): NREG and ADDR_W constants, and the REG_ZERO index constant.
- Storage is a flat array inside regfile_sb.
- Sub-module regfile_scoreboard holds the busy vector, the set/clear priority logic and busy_cnt. It exposes busy and busy_cnt.

Test Plan:
- Reset: write r5 = 0x1234, then pulse rstn low asynchronously between edges -> rdata for r5 is 0 immediately, busy_cnt = 0.
- r0 protection: wb_valid with wb_rd = 0 and wb_data = 0xFFFFFFFF; issue rs1 = 0 -> rdata1 = 0; issue_rd = 0 -> busy_cnt stays 0.
- RAW hazard: issue rd = 3 (accepted, busy_cnt = 1), then issue rs1 = 3 -> issue_ready = 0 until wb r3 = 0xAA.
  - With bypass: ready in the wb cycle with rdata1 = 0xAA.
  - Without bypass: ready one cycle later.
- WAW: r7 busy, issue rd = 7 -> issue_ready = 0; after wb r7 -> accepted, busy_cnt back to 1.
- Simultaneous set/clear: wb r9 and an accepted issue rd = 9 in the same cycle -> busy[9] = 1, storage r9 = wb_data, busy_cnt unchanged.
- Fill: issue rd = 1..31 back-to-back with no wb -> busy_cnt = 31; then wb all 31 -> busy_cnt = 0, no wrap.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb_pkg
// Purpose  : Shared constants and types for the regfile_sb register file and
//            its busy scoreboard.
//            WIDTH_DEF / NREG_DEF / ADDR_W_DEF : default geometry.
//            REG_ZERO                          : hard-wired zero register index.
//            cnt_op_e / cnt_op()               : busy counter update encoding.
// Revision : 1.0  initial release
// ============================================================================
package regfile_sb_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int NREG_DEF   = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    // Net effect of one cycle's set/clear events on the busy population.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // A set on one register and a clear on another cancel out.
    function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
        if (inc && !dec)      return CNT_INC;
        else if (dec && !inc) return CNT_DEC;
        else                  return CNT_HOLD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Per-register busy bits with set-over-clear priority and a
//            registered population count.
// Ports    : clk, rstn                 clock / async active-low reset
//            i_set_valid, i_set_idx    mark a register busy (issue accept)
//            i_clr_valid, i_clr_idx    clear a busy register (write-back)
//            o_busy                    busy vector (bit 0 always 0)
//            o_busy_cnt                number of busy registers
// Revision : 1.0  initial release
// ============================================================================
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_set_valid,
    input  logic [ADDR_W-1:0] i_set_idx,
    input  logic              i_clr_valid,
    input  logic [ADDR_W-1:0] i_clr_idx,
    output logic [NREG-1:0]   o_busy,
    output logic [ADDR_W:0]   o_busy_cnt
);

    logic [NREG-1:0] r_busy;
    logic [ADDR_W:0] r_cnt;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_set;
    logic            w_clr;
    logic            w_inc;
    logic            w_dec;
    cnt_op_e         w_op;

    // Register 0 never takes part in the scoreboard.
    assign w_set = i_set_valid && (i_set_idx != ADDR_W'(REG_ZERO));
    assign w_clr = i_clr_valid && (i_clr_idx != ADDR_W'(REG_ZERO));

    // Count only real transitions so the counter tracks popcount exactly:
    // a set of an already-busy bit adds nothing, and a clear overridden by
    // a same-register set removes nothing.
    assign w_inc = w_set && !r_busy[i_set_idx];
    assign w_dec = w_clr && r_busy[i_clr_idx] && !(w_set && (i_set_idx == i_clr_idx));
    assign w_op  = cnt_op(w_inc, w_dec);

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr) w_busy_nxt[i_clr_idx] = 1'b0;
        if (w_set) w_busy_nxt[i_set_idx] = 1'b1;   // set wins over clear
        w_busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            case (w_op)
                CNT_INC: r_cnt <= r_cnt + (ADDR_W+1)'(1);
                CNT_DEC: r_cnt <= r_cnt - (ADDR_W+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_busy_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : 32-entry register file with two combinational read ports, one
//            write-back port and a busy scoreboard that gates instruction
//            issue on RAW/WAW hazards.
// Ports    : clk, rstn                          clock / async active-low reset
//            issue_valid, issue_rs1/rs2/rd     decode request
//            issue_ready                       request accepted this cycle
//            rdata1, rdata2                    operands for rs1 / rs2
//            wb_valid, wb_rd, wb_data          write-back
//            busy_cnt                          registers currently busy
// Config   : REGFILE_SB_BYPASS_EN  when defined, write-back data is forwarded
//            to the read ports and a retiring register does not stall issue.
// Revision : 1.0  initial release
// ============================================================================
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rs1,
    input  logic [ADDR_W-1:0] issue_rs2,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    output logic [WIDTH-1:0]  rdata1,
    output logic [WIDTH-1:0]  rdata2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [WIDTH-1:0]  wb_data,
    output logic [ADDR_W:0]   busy_cnt
);

    logic [WIDTH-1:0] r_mem [NREG];
    logic             w_wb;
    logic [WIDTH-1:0] w_rd1_raw;
    logic [WIDTH-1:0] w_rd2_raw;
    logic [NREG-1:0]  w_busy;
    logic [NREG-1:0]  w_busy_eff;
    logic             w_hazard;

    assign w_wb = wb_valid && (wb_rd != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else if (w_wb) begin
            r_mem[wb_rd] <= wb_data;
        end
    end

    // Register 0 reads as zero regardless of array contents.
    assign w_rd1_raw = (issue_rs1 == ADDR_W'(REG_ZERO)) ? '0 : r_mem[issue_rs1];
    assign w_rd2_raw = (issue_rs2 == ADDR_W'(REG_ZERO)) ? '0 : r_mem[issue_rs2];

`ifdef REGFILE_SB_BYPASS_EN
    // Forward the retiring value and treat its register as already free.
    assign rdata1 = (w_wb && (wb_rd == issue_rs1)) ? wb_data : w_rd1_raw;
    assign rdata2 = (w_wb && (wb_rd == issue_rs2)) ? wb_data : w_rd2_raw;

    always_comb begin
        w_busy_eff = w_busy;
        if (w_wb) w_busy_eff[wb_rd] = 1'b0;
    end
`else
    assign rdata1     = w_rd1_raw;
    assign rdata2     = w_rd2_raw;
    assign w_busy_eff = w_busy;
`endif

    // rd is checked as well so two writers to one register never overlap.
    assign w_hazard    = w_busy_eff[issue_rs1] | w_busy_eff[issue_rs2] | w_busy_eff[issue_rd];
    assign issue_ready = issue_valid & ~w_hazard;

    regfile_scoreboard #(
        .NREG   (NREG),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .rstn        (rstn),
        .i_set_valid (issue_ready),
        .i_set_idx   (issue_rd),
        .i_clr_valid (wb_valid),
        .i_clr_idx   (wb_rd),
        .o_busy      (w_busy),
        .o_busy_cnt  (busy_cnt)
    );

endmodule
`default_nettype wire
